// File: rtl/gpio_mmio.sv
// gpio_mmio: 32-bit GPIO with synchronized inputs, rising-edge pending/interrupt logic
// and a simple request/ack register bus (one access every two cycles).
module gpio_mmio #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  input  logic [31:0] i_gpio,
  output logic [31:0] o_gpio,
  output logic [31:0] o_gpio_oe,
  output logic        o_irq
);
  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0] synced, prev, data_out, dir, pend, mask, wmask, wbits, w1c, rd_val;
  logic        ready, accept, unused_addr;
  logic [2:0]  sel;
  assign sel         = i_addr[4:2];
  assign unused_addr = ^i_addr[1:0];
  assign synced      = sync_q[SYNC_STAGES-1];
  // ready blocks acceptance on the first edge after reset release
  assign accept      = i_req & ~o_ack & ready;
  assign wmask       = {{8{i_wstrb[3]}}, {8{i_wstrb[2]}}, {8{i_wstrb[1]}}, {8{i_wstrb[0]}}};
  assign wbits       = i_wdata & wmask;
  assign w1c         = (accept && i_we && sel == 3'd5) ? wbits : '0;
  always_comb
    rd_val = sel == 3'd0 ? synced :
             sel == 3'd1 ? data_out :
             sel == 3'd2 ? dir :
             sel == 3'd5 ? pend :
             sel == 3'd6 ? mask : '0;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      sync_q   <= '0;
      prev     <= '0;
      data_out <= OUT_RESET;
      dir      <= '0;
      pend     <= '0;
      mask     <= '0;
      ready    <= 1'b0;
      o_ack    <= 1'b0;
      o_rdata  <= '0;
      o_irq    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_gpio};
      prev    <= synced;
      // a fresh rising edge beats a simultaneous write-1-to-clear
      pend    <= (pend & ~w1c) | (synced & ~prev);
      o_irq   <= |(pend & mask);
      ready   <= 1'b1;
      o_ack   <= accept;
      o_rdata <= accept ? rd_val : '0;
      if (accept && i_we)
        case (sel)
          3'd1:    data_out <= (data_out & ~wmask) | wbits;
          3'd2:    dir      <= (dir & ~wmask) | wbits;
          3'd3:    data_out <= data_out | wbits;
          3'd4:    data_out <= data_out & ~wbits;
          3'd6:    mask     <= (mask & ~wmask) | wbits;
          default: ;
        endcase
    end
  assign o_gpio    = data_out;
  assign o_gpio_oe = dir;
endmodule

// File: doc/gpio_mmio.md
GPIO_MMIO -- requirements
Module: gpio_mmio

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the input synchronizer depth; legal range is 2..4.
REQ-002 SHALL have parameter OUT_RESET, default 32'h0000_0000, giving the reset value of DATA_OUT.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_req, input, 1 bit: CPU access request.
REQ-006 SHALL have port i_we, input, 1 bit: 1 = write, 0 = read; valid with i_req.
REQ-007 SHALL have port i_addr, input, 5 bits: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port i_wdata, input, 32 bits: write data.
REQ-009 SHALL have port i_wstrb, input, 4 bits: byte-lane write enables.
REQ-010 SHALL have port o_ack, output, 1 bit: one-cycle access completion pulse.
REQ-011 SHALL have port o_rdata, output, 32 bits: read data, valid when o_ack=1.
REQ-012 SHALL have port i_gpio, input, 32 bits: asynchronous pin inputs.
REQ-013 SHALL have port o_gpio, output, 32 bits: pin output values.
REQ-014 SHALL have port o_gpio_oe, output, 32 bits: per-pin output enable.
REQ-015 SHALL have port o_irq, output, 1 bit: level interrupt request.

Function
REQ-016 SHALL map registers at these word offsets:
- 0x00 DATA_IN: read-only; synchronized pin values.
- 0x04 DATA_OUT: read/write.
- 0x08 DIR: read/write; 1 = output.
- 0x0C SET: write-only; DATA_OUT |= wdata.
- 0x10 CLR: write-only; DATA_OUT &= ~wdata.
- 0x14 PEND: rising-edge pending bits; write-1-to-clear.
- 0x18 MASK: read/write interrupt enable.
REQ-017 SHALL accept a request on any rising edge where i_req=1 and o_ack=0.
REQ-018 SHALL assert o_ack for exactly one cycle on the edge after acceptance; i_req=1 during an ack cycle SHALL be ignored, so back-to-back accesses take 2 cycles each.
REQ-019 SHALL register o_rdata with the addressed value at acceptance and hold o_rdata at 0 when o_ack=0.
REQ-020 SHALL apply writes at the acceptance edge, per byte lane enabled by i_wstrb; lanes with i_wstrb=0 are unchanged, including for SET, CLR and PEND.
REQ-021 SHALL return 0 on reads of SET, CLR and of unmapped offsets 0x1C; writes to DATA_IN and to unmapped offsets SHALL be acknowledged and have no effect.
REQ-022 SHALL synchronize i_gpio through SYNC_STAGES flops; DATA_IN SHALL reflect a pin change SYNC_STAGES edges after the change.
REQ-023 SHALL keep a previous-value flop after the synchronizer and set PEND[n] on the edge where synced[n]=1 and prev[n]=0, i.e. SYNC_STAGES+1 edges after a pin rise.
REQ-024 SHALL let a new edge-set win when it coincides with a W1C clear of the same PEND bit, so the bit ends at 1.
REQ-025 SHALL drive o_gpio = DATA_OUT and o_gpio_oe = DIR directly from registers, with no combinational path from the bus.
REQ-026 SHALL drive o_irq as the registered value of |(PEND & MASK), updating one edge after PEND or MASK changes.
REQ-027 SHALL update DATA_OUT irrespective of DIR; DIR only gates o_gpio_oe.

Reset
REQ-028 SHALL, while i_rst=0, asynchronously force:
- DATA_OUT = OUT_RESET;
- DIR, PEND, MASK, synchronizer and prev flops = 0;
- o_ack = 0, o_rdata = 0, o_irq = 0.
REQ-029 SHALL discard any access accepted before reset when reset asserts mid-access: no ack is issued after reset and the write is not applied if reset arrives before the acceptance edge.
REQ-030 SHALL accept no request on the first edge after reset deassertion.

Verification
REQ-031 Reset then read DIR and DATA_OUT -> both return 0, with o_ack high exactly one cycle after i_req.
REQ-032 Write DATA_OUT=32'hFFFF_0000 with i_wstrb=4'b0011, then read DATA_OUT -> 32'h0000_0000; repeat with i_wstrb=4'b1100 -> 32'hFFFF_0000.
REQ-033 DATA_OUT=32'h0000_00F0, write SET=32'h0000_000F, then CLR=32'h0000_0030 -> o_gpio=32'h0000_00CF.
REQ-034 Drive i_gpio[24] 0->1 with MASK[24]=1 -> DATA_IN[24]=1 after 2 edges, PEND[24]=1 after 3 edges, o_irq=1 after 4 edges; write PEND=32'h0100_0000 -> o_irq=0 one edge later.
REQ-035 Write-1-to-clear PEND[24] on the same edge a new rise on pin 24 is detected -> PEND[24] remains 1.
REQ-036 Hold i_req=1 continuously for 4 reads -> o_ack pattern 0,1,0,1,0,1,0,1; a read of offset 0x1C returns 0 and is acknowledged.
